// File: rtl/chip_frame_rx_pkg.sv
// Shared types and constants for the chip frame receiver: parser states, sync byte default and
// FIFO entry layout.
package chip_frame_rx_pkg;

    typedef enum logic [2:0] {
        StHunt    = 3'd0,
        StAlign   = 3'd1,
        StIdle    = 3'd2,
        StPayload = 3'd3,
        StDrop    = 3'd4
    } rx_state_e;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hBC;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned FLAG_W  = 2;
    localparam int unsigned ENTRY_W = DATA_W + FLAG_W;

    typedef struct packed {
        logic              first;
        logic              last;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/frame_byte_fifo.sv
// Show-ahead synchronous FIFO with flush; head entry is read combinationally from storage and
// forced to zero while empty.
module frame_byte_fifo #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty      = (count_q == '0);
    assign full       = (count_q == (AW+1)'(DEPTH));
    assign free_count = (AW+1)'(DEPTH) - count_q;
    assign do_pop     = pop && !empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_push    = push && (!full || do_pop);
    assign pop_data   = empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/chip_frame_receiver.sv
// Serial frame receiver: aligns to the sync byte, parses length-prefixed frames into a FIFO.
// Optional live frame counters under CHIP_FRAME_RX_STATS_EN.
module chip_frame_receiver
    import chip_frame_rx_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE  = DEFAULT_SYNC_BYTE,
    parameter int unsigned MAX_LEN    = 16,
    parameter int unsigned FIFO_DEPTH = 32,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        din,
    input  logic        din_en,
    input  logic        flush,
    output logic [7:0]  out_data,
    output logic        out_first,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        locked,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_dropped
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    rx_state_e    state_q, state_d;
    logic [7:0]   shift_q, shift_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   sync_cnt_q, sync_cnt_d;
    logic [7:0]   remaining_q, remaining_d;
    logic         first_q, first_d;
    logic         locked_q, locked_d;
    logic         byte_done, hdr_bad, hdr_fits;
    logic         push, fifo_full, fifo_empty;
    entry_t       push_entry, head;
    logic [CW-1:0] free_count;

    assign shift_d   = din_en ? {shift_q[6:0], din} : shift_q;
    assign byte_done = din_en && (bit_cnt_q == 3'd7);
    assign hdr_bad   = (shift_d == 8'd0) || (shift_d > 8'(MAX_LEN));
    // Admission sees only the current free count; a same-cycle pop is not credited.
    assign hdr_fits  = 16'(free_count) >= 16'(shift_d);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = din_en ? bit_cnt_q + 3'd1 : bit_cnt_q;
        sync_cnt_d  = sync_cnt_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        locked_d    = locked_q;
        push        = 1'b0;
        push_entry  = '0;
        unique case (state_q)
            StHunt: begin
                if (din_en && shift_d == SYNC_BYTE) begin
                    bit_cnt_d  = 3'd0;
                    sync_cnt_d = 8'd1;
                    state_d    = StAlign;
                end
            end
            StAlign: begin
                if (byte_done) begin
                    if (shift_d == SYNC_BYTE) begin
                        sync_cnt_d = sync_cnt_q + 8'd1;
                        if (sync_cnt_q + 8'd1 == 8'(LOCK_COUNT)) begin
                            state_d  = StIdle;
                            locked_d = 1'b1;
                        end
                    end else begin
                        sync_cnt_d = 8'd0;
                        state_d    = StHunt;
                    end
                end
            end
            StIdle: begin
                if (byte_done && shift_d != SYNC_BYTE) begin
                    remaining_d = shift_d;
                    if (hdr_bad) begin
                        state_d    = StHunt;
                        locked_d   = 1'b0;
                        sync_cnt_d = 8'd0;
                    end else if (hdr_fits) begin
                        state_d = StPayload;
                        first_d = 1'b1;
                    end else begin
                        state_d = StDrop;
                    end
                end
            end
            StPayload: begin
                if (byte_done) begin
                    push        = !fifo_full;
                    push_entry  = '{first: first_q, last: (remaining_q == 8'd1), data: shift_d};
                    first_d     = 1'b0;
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) state_d = StIdle;
                end
            end
            StDrop: begin
                if (byte_done) begin
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) state_d = StIdle;
                end
            end
            default: state_d = StHunt;
        endcase
        if (flush) begin
            state_d    = StHunt;
            locked_d   = 1'b0;
            sync_cnt_d = 8'd0;
            bit_cnt_d  = 3'd0;
            push       = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StHunt;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            sync_cnt_q  <= '0;
            remaining_q <= '0;
            first_q     <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            sync_cnt_q  <= sync_cnt_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
            locked_q    <= locked_d;
        end
    end

    frame_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .push       (push),
        .push_data  (push_entry),
        .pop        (out_ready),
        .pop_data   (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .free_count (free_count)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = head.data;
    assign out_first = head.first;
    assign out_last  = head.last;
    assign locked    = locked_q;

`ifdef CHIP_FRAME_RX_STATS_EN
    logic        ok_inc, drop_inc;
    logic [15:0] ok_q, drop_q;

    assign ok_inc   = !flush && byte_done && state_q == StPayload && remaining_q == 8'd1;
    assign drop_inc = !flush && byte_done && state_q == StIdle && shift_d != SYNC_BYTE
                      && !hdr_bad && !hdr_fits;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ok_q   <= '0;
            drop_q <= '0;
        end else begin
            if (ok_inc && ok_q != 16'hFFFF)     ok_q   <= ok_q + 16'd1;
            if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        end
    end

    assign frames_ok      = ok_q;
    assign frames_dropped = drop_q;
`else
    assign frames_ok      = 16'h0;
    assign frames_dropped = 16'h0;
`endif

endmodule
